// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: the primary (WB) write wins, secondary writes queue in a FIFO.
// Tracks pending long-latency writes. Optional forwarding outputs are enabled by WB_BYPASS_EN.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        p_we,
  input  logic [4:0]  p_wn,
  input  logic [31:0] p_d,
  input  logic        s_valid,
  input  logic [4:0]  s_wn,
  input  logic [31:0] s_d,
  output logic        s_ready,
  input  logic        iss,
  input  logic [4:0]  iss_wn,
  input  logic [4:0]  rna,
  input  logic [4:0]  rnb,
  output logic        busy_a,
  output logic        busy_b,
  output logic [4:0]  wn,
  output logic [31:0] d,
  output logic        we
`ifdef WB_BYPASS_EN
  ,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic [31:0] fwd_d
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [4:0]  fifo_wn [DEPTH];
  logic [31:0] fifo_d  [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   pending;

  logic p_req, push, pop;
  logic [4:0]  head_wn;
  logic [31:0] head_d;

  always_comb begin
    p_req   = p_we && (p_wn != 5'd0);
    s_ready = (count < (AW+1)'(DEPTH));
    push    = s_valid && s_ready;
    pop     = !p_req && (count != '0);
    head_wn = fifo_wn[rd_ptr];
    head_d  = fifo_d[rd_ptr];
    busy_a  = (rna != 5'd0) && pending[rna];
    busy_b  = (rnb != 5'd0) && pending[rnb];
  end

  // Storage carries no reset; validity is governed solely by count and pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wn[wr_ptr] <= s_wn;
      fifo_d[wr_ptr]  <= s_d;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      we <= 1'b0;
      wn <= '0;
      d  <= '0;
    end else if (p_req) begin
      we <= 1'b1;
      wn <= p_wn;
      d  <= p_d;
    end else if (pop) begin
      we <= (head_wn != 5'd0);
      wn <= head_wn;
      d  <= head_d;
    end else begin
      we <= 1'b0;
    end
  end

  // The set is applied after the clear so that a coincident issue keeps the bit high.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pending <= '0;
    end else begin
      if (pop && (head_wn != 5'd0)) pending[head_wn] <= 1'b0;
      if (iss && (iss_wn != 5'd0))  pending[iss_wn]  <= 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    fwd_a = we && (wn == rna) && (rna != 5'd0);
    fwd_b = we && (wn == rnb) && (rnb != 5'd0);
    fwd_d = d;
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued by stimulus and
// checked by an independent monitor; status outputs are checked directly.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        clrn;
  logic        p_we, s_valid, iss;
  logic [4:0]  p_wn, s_wn, iss_wn, rna, rnb;
  logic [31:0] p_d, s_d;
  logic        s_ready, busy_a, busy_b, we;
  logic [4:0]  wn;
  logic [31:0] d;
`ifdef WB_BYPASS_EN
  logic        fwd_a, fwd_b;
  logic [31:0] fwd_d;
`endif

  int vectors = 0;
  int errors  = 0;
  logic [36:0] exp_q [$];

  regfile_write_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .clrn(clrn),
    .p_we(p_we), .p_wn(p_wn), .p_d(p_d),
    .s_valid(s_valid), .s_wn(s_wn), .s_d(s_d), .s_ready(s_ready),
    .iss(iss), .iss_wn(iss_wn), .rna(rna), .rnb(rnb),
    .busy_a(busy_a), .busy_b(busy_b),
    .wn(wn), .d(d), .we(we)
`ifdef WB_BYPASS_EN
    , .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_d(fwd_d)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] v);
    exp_q.push_back({r, v});
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every asserted write must match the head of the expected queue.
  initial begin
    logic [36:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (we === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_write: got wn=%0d d=%h, expected no write", wn, d);
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if ({wn, d} !== e) begin
            errors++;
            $display("FAIL write_order: got wn=%0d d=%h, expected wn=%0d d=%h",
                     wn, d, e[36:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    clrn = 1'b0; p_we = 0; p_wn = 0; p_d = 0; s_valid = 0; s_wn = 0; s_d = 0;
    iss = 0; iss_wn = 0; rna = 0; rnb = 0;
    step(); step();
    chk("rst_we", 32'(we), 0);
    chk("rst_wn", 32'(wn), 0);
    chk("rst_d", d, 0);
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_busy_a", 32'(busy_a), 0);
    clrn = 1'b1;
    step();

    // Single primary write, then idle holds wn/d.
    p_we = 1; p_wn = 5; p_d = 32'hA5A5A5A5; expect_wr(5, 32'hA5A5A5A5);
    step();
    p_we = 0;
    step();
    chk("idle_we", 32'(we), 0);
    chk("idle_wn_hold", 32'(wn), 5);
    chk("idle_d_hold", d, 32'hA5A5A5A5);

    // Primary wins twice while secondary queues r3, r4.
    expect_wr(7, 32'h77); expect_wr(7, 32'h77); expect_wr(3, 3); expect_wr(4, 4);
    p_we = 1; p_wn = 7; p_d = 32'h77; s_valid = 1; s_wn = 3; s_d = 3;
    chk("sr_1", 32'(s_ready), 1);
    step();
    s_wn = 4; s_d = 4;
    chk("sr_2", 32'(s_ready), 1);
    step();
    p_we = 0; s_valid = 0;
    chk("sr_3", 32'(s_ready), 1);
    drain();

    // Fill the FIFO under primary pressure; fifth entry waits for space.
    p_we = 1; p_wn = 8; p_d = 32'h88;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1; s_wn = 5'(10 + i); s_d = 32'h100 + 32'(i);
      chk("fill_s_ready", 32'(s_ready), (i < 4) ? 1 : 0);
      expect_wr(8, 32'h88);
      step();
    end
    for (int i = 0; i < 5; i++) expect_wr(5'(10 + i), 32'h100 + 32'(i));
    p_we = 0;
    step();
    chk("full_pop_ready", 32'(s_ready), 1);
    step();
    s_valid = 0;
    drain();

    // Scoreboard set/clear, then coincident set and clear.
    iss = 1; iss_wn = 9; rna = 9; rnb = 9;
    step();
    iss = 0;
    chk("busy_a_set", 32'(busy_a), 1);
    chk("busy_b_set", 32'(busy_b), 1);
    s_valid = 1; s_wn = 9; s_d = 32'h99; expect_wr(9, 32'h99);
    step();
    s_valid = 0;
    chk("busy_a_queued", 32'(busy_a), 1);
    step();
    chk("busy_a_clear", 32'(busy_a), 0);
    s_valid = 1; s_wn = 9; s_d = 32'h9A; expect_wr(9, 32'h9A);
    step();
    s_valid = 0; iss = 1; iss_wn = 9;
    step();
    iss = 0;
    chk("busy_a_set_wins", 32'(busy_a), 1);
    rnb = 0;
    #1;
    chk("busy_b_r0", 32'(busy_b), 0);
    drain();

    // Reset mid-operation discards queued entries and pending bits.
    p_we = 1; p_wn = 8; p_d = 32'h88;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1; s_wn = 5'(20 + i); s_d = 32'h200 + 32'(i);
      expect_wr(8, 32'h88);
      step();
    end
    s_valid = 0; p_we = 0; clrn = 0;
    #1;
    chk("mid_rst_we", 32'(we), 0);
    chk("mid_rst_wn", 32'(wn), 0);
    chk("mid_rst_s_ready", 32'(s_ready), 1);
    chk("mid_rst_busy_a", 32'(busy_a), 0);
    step(); step();
    clrn = 1;
    for (int i = 0; i < 10; i++) step();
    chk("post_rst_busy_a", 32'(busy_a), 0);

    // Register 0 never produces a write.
    p_we = 1; p_wn = 0; p_d = 32'hDEAD;
    step();
    p_we = 0;
    step();
    chk("p_r0_we", 32'(we), 0);
    chk("p_r0_d_hold", d, 0);
    s_valid = 1; s_wn = 0; s_d = 32'hBEEF;
    step();
    s_valid = 0;
    step();
    chk("s_r0_we", 32'(we), 0);
    chk("s_r0_d", d, 32'hBEEF);
    step();

`ifdef WB_BYPASS_EN
    p_we = 1; p_wn = 6; p_d = 32'h66; rna = 6; rnb = 6; expect_wr(6, 32'h66);
    step();
    p_we = 0;
    chk("fwd_a", 32'(fwd_a), 1);
    chk("fwd_b", 32'(fwd_b), 1);
    chk("fwd_d", fwd_d, 32'h66);
    rna = 0;
    #1;
    chk("fwd_a_r0", 32'(fwd_a), 0);
    step();
`endif

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
